hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Decode-stage hazard unit for the 16-register, 4-bit-address pipeline. It is the producer-side counterpart of the EX-stage forwarding unit.
- Tracks in-flight load destinations in a busy scoreboard. Stalls decode on load-use hazards that forwarding cannot cover, and freezes the pipeline while memory is not ready.
- Sits beside the ID stage. Drives the PC/IF-ID write enables and the ID/EX bubble, and takes writeback status from the MEM/WB register.

Parameters:
- NREG, 16, number of architectural registers; register 0 is hardwired zero.
- AW, 4, register address width.
- STALL_LIMIT, 64, consecutive stall cycles before the watchdog error is raised.
- CW, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous reset, active high.
- id_valid  in  1  decode holds a real instruction.
- id_rs  in  AW  decode source register A.
- id_rt  in  AW  decode source register B.
- id_rs_used  in  1  instruction reads rs.
- id_rt_used  in  1  instruction reads rt.
- id_rd  in  AW  decode destination register.
- id_is_load  in  1  instruction is a load writing id_rd.
- wb_rd  in  AW  MEM/WB destination register.
- wb_load_rw  in  1  a load result is being written back this cycle.
- mem_ready  in  1  data memory access completes this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register write enable.
- idex_bubble  out  1  inject NOP into ID/EX.
- freeze  out  1  hold EX/MEM and MEM/WB.
- busy  out  NREG  scoreboard vector; bit 0 is always 0.
- stall_count  out  CW  saturating count of stall cycles.
- watchdog_err  out  1  sticky error: stall persisted too long.

Behaviour:
- Reset (async, rst=1): busy=0, FSM=RUN, stall_count=0, watchdog_err=0, internal run-length counter=0. While in reset: pc_write=1, ifid_write=1, idex_bubble=0, freeze=0.
- Hazard term:
  - hz_a = id_valid & id_rs_used & busy[id_rs] & ~clr_a.
  - hz_b is the same for rt.
  - clr_x = wb_load_rw & (wb_rd == id_x) & (wb_rd != 0).
  - The clr term is a same-cycle bypass: forwarding select 01 covers it, so there is no stall.
- FSM states, evaluated each cycle with priority MEM_WAIT > LU_STALL > RUN:
  - MEM_WAIT: entered whenever mem_ready=0. Outputs freeze=1, pc_write=0, ifid_write=0, idex_bubble=0. The scoreboard neither sets nor clears. Leaves when mem_ready=1, to LU_STALL if a hazard is present, else to RUN.
  - LU_STALL: entered when mem_ready=1 and (hz_a|hz_b). Outputs pc_write=0, ifid_write=0, idex_bubble=1, freeze=0. Leaves to RUN when the hazard clears.
  - RUN: all enables 1, bubble 0, freeze 0.
- Outputs are combinational from the current inputs and busy, so a stall takes effect in the same cycle the hazard is present. The registered state is used only for counters and the watchdog.
- Scoreboard update, only when freeze=0:
  - Set busy[id_rd] when id_valid & id_is_load & id_rd != 0 & no stall this cycle.
  - Clear busy[wb_rd] when wb_load_rw & wb_rd != 0.
  - Set and clear on the same register in the same cycle: set wins (a new load is in flight).
  - Writes to register 0 are ignored.
- A stalled instruction never sets busy, because it has not issued.
- stall_count: increments on every cycle with pc_write=0 and saturates at 2^CW-1 without wrapping.
- Watchdog:
  - The run-length counter increments while pc_write=0 and resets to 0 when pc_write=1.
  - When it reaches STALL_LIMIT, watchdog_err is set. The flag is sticky until rst.
  - The run-length counter saturates at STALL_LIMIT.
- Reset mid-stall: all state clears immediately and the next cycle is RUN with an empty scoreboard.

Decomposition:
- Shared package (pipeline_pkg):
  - AW and NREG.
  - FSM state encoding: RUN=2'b00, LU_STALL=2'b01, MEM_WAIT=2'b10.
  - REG_ZERO constant.
  - These are reused by the forwarding unit and the register file.
- One natural sub-module: sat_counter (parameterised width, inc, clear, saturate). It is instantiated twice, for stall_count and for the watchdog run length.

Test Plan:
- Load-use: load r3 issues, next instr add rs=r3 -> exactly one cycle with pc_write=0, idex_bubble=1; busy[3]=1 until wb_load_rw with wb_rd=3, then 0; stall_count=1.
- WB bypass: busy[5]=1, id_rs=5 while wb_load_rw=1, wb_rd=5 -> no stall, busy[5] cleared next cycle.
- Register zero: load r0, then read r0 -> busy stays 0, no stall.
- Memory wait: mem_ready=0 for 3 cycles during a pending hazard -> freeze=1, idex_bubble=0, busy unchanged for those cycles, then LU_STALL, then RUN.
- Simultaneous set/clear: wb clears r7 while a new load r7 issues -> busy[7]=1 afterwards.
- Watchdog: hold mem_ready=0 for 64 cycles -> watchdog_err=1 at cycle 64, still 1 after mem_ready=1; assert rst mid-stall -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and hazard FSM encoding.
// Reused by the forwarding unit, register file and hazard scoreboard.
package pipeline_pkg;

  localparam int AW   = 4;
  localparam int NREG = 16;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_e;

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage load-use hazard unit with busy scoreboard,
// memory-wait freeze, stall counter and stall watchdog.
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int NREG        = pipeline_pkg::NREG,
  parameter int AW          = pipeline_pkg::AW,
  parameter int STALL_LIMIT = 64,
  parameter int CW          = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_is_load,
  input  logic [AW-1:0]   wb_rd,
  input  logic            wb_load_rw,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            idex_bubble,
  output logic            freeze,
  output logic [NREG-1:0] busy,
  output logic [CW-1:0]   stall_count,
  output logic            watchdog_err
);

  localparam int RW = $clog2(STALL_LIMIT + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STALL_LIMIT);

  logic [NREG-1:0] busy_q, busy_d;
  logic [RW-1:0]   run_q;
  logic            err_q;
  logic            wb_clr, clr_a, clr_b;
  logic            hz_a, hz_b, set_ok;
  logic            run_at_lim;
  hz_state_e       state;

  // A writeback to the same register this cycle is bypassed, not stalled.
  assign wb_clr = wb_load_rw && (wb_rd != REG_ZERO);
  assign clr_a  = wb_clr && (wb_rd == id_rs);
  assign clr_b  = wb_clr && (wb_rd == id_rt);
  assign hz_a   = id_valid && id_rs_used && busy_q[id_rs] && !clr_a;
  assign hz_b   = id_valid && id_rt_used && busy_q[id_rt] && !clr_b;

  always_comb begin
    state = RUN;
    if (rst) begin
      state = RUN;
    end else if (!mem_ready) begin
      state = MEM_WAIT;
    end else if (hz_a || hz_b) begin
      state = LU_STALL;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    freeze      = 1'b0;
    unique case (state)
      MEM_WAIT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        freeze     = 1'b1;
      end
      LU_STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign set_ok = id_valid && id_is_load &&
                  (id_rd != REG_ZERO) && (state == RUN);

  // Set is applied after clear so a reissued load wins.
  always_comb begin
    busy_d = busy_q;
    if (!freeze) begin
      if (wb_clr) begin
        busy_d[wb_rd] = 1'b0;
      end
      if (set_ok) begin
        busy_d[id_rd] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

  sat_counter #(
    .W   (CW),
    .MAX ({CW{1'b1}})
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (!pc_write),
    .clr_i (1'b0),
    .q_o   (stall_count)
  );

  sat_counter #(
    .W   (RW),
    .MAX (RUN_MAX)
  ) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (!pc_write),
    .clr_i (pc_write),
    .q_o   (run_q)
  );

  assign run_at_lim = (run_q == RUN_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (run_at_lim) begin
      err_q <= 1'b1;
    end
  end

  assign watchdog_err = err_q || run_at_lim;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard.
// Expected per-cycle results are queued at drive time and popped at sample time.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs_used, id_rt_used, id_is_load;
  logic [3:0]  id_rs, id_rt, id_rd, wb_rd;
  logic        wb_load_rw, mem_ready;
  logic        pc_write, ifid_write, idex_bubble, freeze;
  logic [15:0] busy;
  logic [15:0] stall_count;
  logic        watchdog_err;

  int total = 0;
  int bad   = 0;
  int sc_exp = 0;

  typedef struct packed {
    logic pc;
    logic bub;
    logic frz;
  } comb_t;

  typedef struct packed {
    logic [15:0] busy;
    logic [15:0] sc;
    logic        err;
  } seq_t;

  comb_t cq[$];
  seq_t  sq[$];

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .id_rd        (id_rd),
    .id_is_load   (id_is_load),
    .wb_rd        (wb_rd),
    .wb_load_rw   (wb_load_rw),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_bubble  (idex_bubble),
    .freeze       (freeze),
    .busy         (busy),
    .stall_count  (stall_count),
    .watchdog_err (watchdog_err)
  );

  task automatic idle();
    id_valid   = 1'b0;
    id_rs      = 4'd0;
    id_rt      = 4'd0;
    id_rs_used = 1'b0;
    id_rt_used = 1'b0;
    id_rd      = 4'd0;
    id_is_load = 1'b0;
    wb_rd      = 4'd0;
    wb_load_rw = 1'b0;
    mem_ready  = 1'b1;
  endtask

  task automatic instr(input logic [3:0] rs, input logic rsu,
                       input logic [3:0] rd, input logic ld);
    id_valid   = 1'b1;
    id_rs      = rs;
    id_rs_used = rsu;
    id_rt      = 4'd0;
    id_rt_used = 1'b0;
    id_rd      = rd;
    id_is_load = ld;
  endtask

  // Inputs are already applied (posedge+1); check comb at negedge,
  // registered state at the following posedge+1.
  task automatic cyc(input string tag, input logic pc, input logic bub,
                     input logic frz, input logic [15:0] b,
                     input logic err);
    comb_t ec;
    seq_t  es;
    cq.push_back('{pc, bub, frz});
    if (!pc) sc_exp++;
    sq.push_back('{b, 16'(sc_exp), err});
    @(negedge clk);
    ec = cq.pop_front();
    total++;
    if (pc_write !== ec.pc) begin
      bad++;
      $display("FAIL %s pc_write got=%b want=%b", tag, pc_write, ec.pc);
    end
    total++;
    if (ifid_write !== ec.pc) begin
      bad++;
      $display("FAIL %s ifid_write got=%b want=%b", tag, ifid_write, ec.pc);
    end
    total++;
    if (idex_bubble !== ec.bub) begin
      bad++;
      $display("FAIL %s idex_bubble got=%b want=%b", tag, idex_bubble, ec.bub);
    end
    total++;
    if (freeze !== ec.frz) begin
      bad++;
      $display("FAIL %s freeze got=%b want=%b", tag, freeze, ec.frz);
    end
    @(posedge clk);
    #1;
    es = sq.pop_front();
    total++;
    if (busy !== es.busy) begin
      bad++;
      $display("FAIL %s busy got=%h want=%h", tag, busy, es.busy);
    end
    total++;
    if (stall_count !== es.sc) begin
      bad++;
      $display("FAIL %s stall_count got=%0d want=%0d", tag, stall_count, es.sc);
    end
    total++;
    if (watchdog_err !== es.err) begin
      bad++;
      $display("FAIL %s watchdog_err got=%b want=%b", tag, watchdog_err, es.err);
    end
  endtask

  task automatic test_reset();
    idle();
    rst        = 1'b1;
    id_valid   = 1'b1;
    id_is_load = 1'b1;
    id_rd      = 4'd2;
    mem_ready  = 1'b0;
    #3;
    total++;
    if ({pc_write, ifid_write, idex_bubble, freeze} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=1100",
               {pc_write, ifid_write, idex_bubble, freeze});
    end
    @(posedge clk);
    #1;
    total++;
    if ({busy, stall_count, watchdog_err} !== 33'd0) begin
      bad++;
      $display("FAIL reset_state busy=%h sc=%0d err=%b want 0/0/0",
               busy, stall_count, watchdog_err);
    end
    idle();
    rst = 1'b0;
    cyc("post_reset", 1, 0, 0, 16'h0000, 0);
  endtask

  task automatic test_load_use();
    idle(); instr(4'd1, 1, 4'd3, 1);
    cyc("lu_load", 1, 0, 0, 16'h0008, 0);
    idle(); instr(4'd3, 1, 4'd4, 0);
    cyc("lu_stall", 0, 1, 0, 16'h0008, 0);
    idle(); instr(4'd3, 1, 4'd4, 0);
    wb_load_rw = 1'b1; wb_rd = 4'd3;
    cyc("lu_wb", 1, 0, 0, 16'h0000, 0);
    idle();
    cyc("lu_idle", 1, 0, 0, 16'h0000, 0);
  endtask

  task automatic test_wb_bypass();
    idle(); instr(4'd0, 0, 4'd5, 1);
    cyc("byp_load", 1, 0, 0, 16'h0020, 0);
    idle(); instr(4'd5, 1, 4'd6, 0);
    wb_load_rw = 1'b1; wb_rd = 4'd5;
    cyc("byp_use", 1, 0, 0, 16'h0000, 0);
  endtask

  task automatic test_reg_zero();
    idle(); instr(4'd0, 0, 4'd0, 1);
    cyc("r0_load", 1, 0, 0, 16'h0000, 0);
    idle(); instr(4'd0, 1, 4'd1, 0);
    wb_load_rw = 1'b1; wb_rd = 4'd0;
    cyc("r0_read", 1, 0, 0, 16'h0000, 0);
  endtask

  task automatic test_mem_wait();
    idle(); instr(4'd0, 0, 4'd6, 1);
    cyc("mw_load", 1, 0, 0, 16'h0040, 0);
    for (int k = 0; k < 3; k++) begin
      idle(); instr(4'd6, 1, 4'd2, 0);
      mem_ready = 1'b0;
      cyc("mw_freeze", 0, 0, 1, 16'h0040, 0);
    end
    idle(); instr(4'd6, 1, 4'd2, 0);
    cyc("mw_lustall", 0, 1, 0, 16'h0040, 0);
    idle(); instr(4'd6, 1, 4'd2, 0);
    wb_load_rw = 1'b1; wb_rd = 4'd6;
    cyc("mw_run", 1, 0, 0, 16'h0000, 0);
  endtask

  task automatic test_set_clear();
    idle(); instr(4'd0, 0, 4'd7, 1);
    cyc("sc_load", 1, 0, 0, 16'h0080, 0);
    idle(); instr(4'd0, 0, 4'd7, 1);
    wb_load_rw = 1'b1; wb_rd = 4'd7;
    cyc("sc_same", 1, 0, 0, 16'h0080, 0);
    idle();
    wb_load_rw = 1'b1; wb_rd = 4'd7;
    cyc("sc_clear", 1, 0, 0, 16'h0000, 0);
  endtask

  task automatic test_stalled_load();
    idle(); instr(4'd0, 0, 4'd8, 1);
    cyc("sl_load8", 1, 0, 0, 16'h0100, 0);
    idle(); instr(4'd8, 1, 4'd9, 1);
    cyc("sl_stall", 0, 1, 0, 16'h0100, 0);
    idle(); instr(4'd8, 1, 4'd9, 1);
    wb_load_rw = 1'b1; wb_rd = 4'd8;
    cyc("sl_issue", 1, 0, 0, 16'h0200, 0);
    idle();
    wb_load_rw = 1'b1; wb_rd = 4'd9;
    cyc("sl_clear", 1, 0, 0, 16'h0000, 0);
  endtask

  task automatic test_watchdog();
    idle(); instr(4'd0, 0, 4'd10, 1);
    cyc("wd_load", 1, 0, 0, 16'h0400, 0);
    for (int k = 1; k <= 64; k++) begin
      idle();
      mem_ready = 1'b0;
      cyc("wd_wait", 0, 0, 1, 16'h0400, (k == 64));
    end
    idle();
    cyc("wd_sticky1", 1, 0, 0, 16'h0400, 1);
    cyc("wd_sticky2", 1, 0, 0, 16'h0400, 1);
    for (int k = 0; k < 2; k++) begin
      idle();
      mem_ready = 1'b0;
      cyc("wd_restall", 0, 0, 1, 16'h0400, 1);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({pc_write, ifid_write, idex_bubble, freeze} !== 4'b1100) begin
      bad++;
      $display("FAIL midrst_ctl got=%b want=1100",
               {pc_write, ifid_write, idex_bubble, freeze});
    end
    total++;
    if ({busy, stall_count, watchdog_err} !== 33'd0) begin
      bad++;
      $display("FAIL midrst_state busy=%h sc=%0d err=%b want 0/0/0",
               busy, stall_count, watchdog_err);
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    sc_exp = 0;
    idle();
    cyc("post_midrst", 1, 0, 0, 16'h0000, 0);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_wb_bypass();
    test_reg_zero();
    test_mem_wait();
    test_set_clear();
    test_stalled_load();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
